// File: rtl/median_feeder.sv
// Median filter front end: collects a 9-byte window from the host, streams it to the filter and captures the median.
// Optional result counter WIN_CNT is compiled in when MEDIAN_FEEDER_STATS_EN is defined.
module median_feeder #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [7:0]  IN_DATA,
    input  logic        IN_VALID,
    output logic        IN_READY,
    output logic [7:0]  DI,
    output logic        DSI,
    input  logic [7:0]  DO,
    input  logic        DSO,
    output logic [7:0]  RES_DATA,
    output logic        RES_VALID,
    input  logic        RES_ACK,
    output logic        TIMEOUT,
`ifdef MEDIAN_FEEDER_STATS_EN
    output logic [15:0] WIN_CNT,
`endif
    output logic [2:0]  state_dbg_o
);

    // Host handshake: a byte transfers on every rising edge where IN_READY and IN_VALID are both 1.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FILL = 3'd1,
        SEND = 3'd2,
        WAIT = 3'd3,
        HOLD = 3'd4
    } state_e;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e     state_q;
    logic [3:0] k_q;
    logic [7:0] cnt_q;
    logic       in_ready_q;
    logic       dsi_q;
    logic [7:0] di_q;
    logic [7:0] res_data_q;
    logic       res_valid_q;
    logic       timeout_q;
    logic [7:0] win_buf_q [9];
`ifdef MEDIAN_FEEDER_STATS_EN
    logic [15:0] win_cnt_q;
`endif

    // Window storage is deliberately outside the reset domain; a partial window is dropped via k_q.
    always_ff @(posedge CLK) begin
        if (in_ready_q && IN_VALID) begin
            win_buf_q[k_q] <= IN_DATA;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            k_q         <= 4'd0;
            cnt_q       <= 8'd0;
            in_ready_q  <= 1'b0;
            dsi_q       <= 1'b0;
            di_q        <= 8'h00;
            res_data_q  <= 8'h00;
            res_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
`ifdef MEDIAN_FEEDER_STATS_EN
            win_cnt_q   <= 16'h0000;
`endif
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    state_q    <= FILL;
                    in_ready_q <= 1'b1;
                    k_q        <= 4'd0;
                end
                FILL: begin
                    if (IN_VALID) begin
                        if (k_q == 4'd8) begin
                            // buf[0] goes out on the very next cycle; k_q then names the byte after it.
                            in_ready_q <= 1'b0;
                            dsi_q      <= 1'b1;
                            di_q       <= win_buf_q[0];
                            k_q        <= 4'd1;
                            state_q    <= SEND;
                        end else begin
                            k_q <= k_q + 4'd1;
                        end
                    end
                end
                SEND: begin
                    if (k_q == 4'd9) begin
                        dsi_q   <= 1'b0;
                        di_q    <= 8'h00;
                        k_q     <= 4'd0;
                        cnt_q   <= 8'd0;
                        state_q <= WAIT;
                    end else begin
                        di_q <= win_buf_q[k_q];
                        k_q  <= k_q + 4'd1;
                    end
                end
                WAIT: begin
                    // A result arriving on the last allowed cycle still counts as a capture.
                    if (DSO) begin
                        res_data_q  <= DO;
                        res_valid_q <= 1'b1;
                        state_q     <= HOLD;
`ifdef MEDIAN_FEEDER_STATS_EN
                        if (win_cnt_q != 16'hFFFF) begin
                            win_cnt_q <= win_cnt_q + 16'd1;
                        end
`endif
                    end else if (cnt_q == TO_LAST) begin
                        timeout_q  <= 1'b1;
                        in_ready_q <= 1'b1;
                        state_q    <= FILL;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                HOLD: begin
                    if (RES_ACK) begin
                        res_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= FILL;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign IN_READY    = in_ready_q;
    assign DSI         = dsi_q;
    assign DI          = di_q;
    assign RES_DATA    = res_data_q;
    assign RES_VALID   = res_valid_q;
    assign TIMEOUT     = timeout_q;
    assign state_dbg_o = state_q;
`ifdef MEDIAN_FEEDER_STATS_EN
    assign WIN_CNT     = win_cnt_q;
`endif

endmodule

// File: tb/tb_median_feeder.sv
// Bench for median_feeder: drives host windows, models the filter, scoreboards DI bytes and captured medians.
// Build with MEDIAN_FEEDER_STATS_EN defined to also check WIN_CNT.
module tb_median_feeder;

    localparam int TO_CYC = 64;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_FILL = 3'd1;
    localparam logic [2:0] S_SEND = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd4;

    typedef logic [7:0] win_t [9];

    logic       CLK = 1'b0;
    logic       reset;
    logic [7:0] IN_DATA;
    logic       IN_VALID;
    logic       IN_READY;
    logic [7:0] DI;
    logic       DSI;
    logic [7:0] DO;
    logic       DSO;
    logic [7:0] RES_DATA;
    logic       RES_VALID;
    logic       RES_ACK;
    logic       TIMEOUT;
    logic [2:0] state_dbg;
`ifdef MEDIAN_FEEDER_STATS_EN
    logic [15:0] WIN_CNT;
`endif

    median_feeder #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .CLK(CLK), .reset(reset),
        .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .DI(DI), .DSI(DSI), .DO(DO), .DSO(DSO),
        .RES_DATA(RES_DATA), .RES_VALID(RES_VALID), .RES_ACK(RES_ACK),
        .TIMEOUT(TIMEOUT),
`ifdef MEDIAN_FEEDER_STATS_EN
        .WIN_CNT(WIN_CNT),
`endif
        .state_dbg_o(state_dbg)
    );

    // Clock and watchdog
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Scoreboard state
    logic [7:0] exp_q [$];
    logic [7:0] res_q [$];
    int checks = 0;
    int errors = 0;
    int dsi_seen = 0;
    int run = 0;
    int exp_win = 0;
    bit mon_en = 1'b0;
    logic [7:0] last_res = 8'h00;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // DI stream monitor: every DSI byte is popped from the expected queue.
    always @(negedge CLK) begin
        if (!mon_en) begin
            run = 0;
        end else if (DSI) begin
            dsi_seen++;
            run++;
            if (exp_q.size() == 0) check("di_unexpected_dsi", {31'b0, DSI}, 32'd0);
            else check("di", {24'b0, DI}, {24'b0, exp_q.pop_front()});
        end else begin
            check("di_idle_zero", {24'b0, DI}, 32'd0);
            if (run != 0) begin
                check("dsi_run_len", run, 9);
                run = 0;
            end
        end
    end

    function automatic logic [7:0] median9(input win_t w);
        win_t s = w;
        logic [7:0] t;
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < 8 - i; j++) begin
                if (s[j] > s[j+1]) begin
                    t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                end
            end
        end
        return s[4];
    endfunction

    task automatic rand_win(output win_t w);
        for (int i = 0; i < 9; i++) w[i] = 8'($urandom_range(0, 255));
    endtask

    // Driver: offers w[start..start+n-1]; gaps gives the IN_VALID pattern 1,0,0,1,0,0,...
    task automatic feed(input win_t w, input int start, input int n, input bit gaps, output int rdy);
        int acc = 0;
        int cyc = 0;
        rdy = 0;
        while (acc < n && cyc < 200) begin
            IN_VALID = gaps ? (cyc % 3 == 0) : 1'b1;
            IN_DATA  = w[start + acc];
            @(negedge CLK);
            if (IN_READY) rdy++;
            if (IN_READY && IN_VALID) begin
                exp_q.push_back(IN_DATA);
                acc++;
            end
            @(posedge CLK); #1;
            cyc++;
        end
        IN_VALID = 1'b0;
        IN_DATA  = 8'h00;
        if (acc < n) check("feed_accept_timeout", acc, n);
    endtask

    // Runs through the 9 SEND cycles; optionally holds DSO high (to be ignored) during the first 8.
    task automatic wait_send(input bit dso_in_send);
        for (int i = 0; i < 9; i++) begin
            DSO = dso_in_send && (i < 8);
            DO  = 8'hEE;
            @(negedge CLK);
            if (i == 0) check("dsi_first_cycle", {31'b0, DSI}, 32'd1);
            check("in_ready_low_send", {31'b0, IN_READY}, 32'd0);
            check("state_send", {29'b0, state_dbg}, {29'b0, S_SEND});
            @(posedge CLK); #1;
        end
        DSO = 1'b0;
        DO  = 8'h00;
    endtask

    // Filter model: answers after 'w' WAIT cycles, host acks 'ack_delay' cycles after RES_VALID rises.
    task automatic do_result(input logic [7:0] val, input int w, input int ack_delay);
        repeat (w) begin @(posedge CLK); #1; end
        DSO = 1'b1;
        DO  = val;
        res_q.push_back(val);
        exp_win++;
        last_res = val;
        @(posedge CLK); #1;
        DSO = 1'b0;
        DO  = 8'h00;
        @(negedge CLK);
        check("res_valid_set", {31'b0, RES_VALID}, 32'd1);
        check("res_data", {24'b0, RES_DATA}, {24'b0, res_q.pop_front()});
        check("no_timeout_on_capture", {31'b0, TIMEOUT}, 32'd0);
        check("state_hold", {29'b0, state_dbg}, {29'b0, S_HOLD});
        for (int i = 0; i < ack_delay; i++) begin
            @(posedge CLK); #1;
            @(negedge CLK);
            check("hold_valid", {31'b0, RES_VALID}, 32'd1);
            check("hold_data", {24'b0, RES_DATA}, {24'b0, val});
        end
        RES_ACK = 1'b1;
        @(posedge CLK); #1;
        RES_ACK = 1'b0;
        @(negedge CLK);
        check("ack_clears_valid", {31'b0, RES_VALID}, 32'd0);
        check("ack_in_ready", {31'b0, IN_READY}, 32'd1);
        @(posedge CLK); #1;
    endtask

    task automatic reset_pulse();
        mon_en = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_dsi", {31'b0, DSI}, 32'd0);
        check("rst_di", {24'b0, DI}, 32'd0);
        check("rst_in_ready", {31'b0, IN_READY}, 32'd0);
        check("rst_state", {29'b0, state_dbg}, {29'b0, S_IDLE});
        check("rst_res_data", {24'b0, RES_DATA}, 32'd0);
        exp_q.delete();
        exp_win = 0;
        last_res = 8'h00;
        @(negedge CLK);
        reset = 1'b1;
        @(posedge CLK); #1;
        mon_en = 1'b1;
    endtask

    initial begin
        win_t w;
        int rdy;
        int snap;
        int n;
        reset = 1'b0; IN_DATA = 8'h00; IN_VALID = 1'b0;
        DO = 8'h00; DSO = 1'b0; RES_ACK = 1'b0;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_in_ready", {31'b0, IN_READY}, 32'd0);
        check("reset_dsi", {31'b0, DSI}, 32'd0);
        check("reset_di", {24'b0, DI}, 32'd0);
        check("reset_res_valid", {31'b0, RES_VALID}, 32'd0);
        check("reset_res_data", {24'b0, RES_DATA}, 32'd0);
        check("reset_timeout", {31'b0, TIMEOUT}, 32'd0);
        check("reset_state", {29'b0, state_dbg}, {29'b0, S_IDLE});
        reset = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        check("idle_to_fill_ready", {31'b0, IN_READY}, 32'd1);
        check("idle_to_fill_state", {29'b0, state_dbg}, {29'b0, S_FILL});
        @(posedge CLK); #1;
        mon_en = 1'b1;

        // Reset mid-FILL, then mid-SEND (5th DSI cycle)
        rand_win(w); feed(w, 0, 5, 1'b0, rdy);
        reset_pulse();
        rand_win(w); feed(w, 0, 9, 1'b0, rdy);
        repeat (4) begin @(posedge CLK); #1; end
        reset_pulse();

        // A fresh window must be complete before any DSI
        snap = dsi_seen;
        rand_win(w); feed(w, 0, 5, 1'b0, rdy);
        repeat (3) begin @(posedge CLK); #1; end
        check("no_dsi_partial_fill", dsi_seen, snap);
        feed(w, 5, 4, 1'b0, rdy);
        wait_send(1'b0);
        do_result(median9(w), 2, 1);

        // Descending stream 9..1, result 3 cycles after last DSI, ack after 4
        for (int i = 0; i < 9; i++) w[i] = 8'(9 - i);
        feed(w, 0, 9, 1'b0, rdy);
        check("ready_cycles", rdy, 9);
        wait_send(1'b0);
        do_result(median9(w), 2, 4);

        // DSO and RES_ACK are ignored while filling
        DSO = 1'b1; DO = 8'hAA; RES_ACK = 1'b1;
        @(posedge CLK); #1;
        DSO = 1'b0; DO = 8'h00; RES_ACK = 1'b0;
        @(negedge CLK);
        check("fill_dso_ignored_valid", {31'b0, RES_VALID}, 32'd0);
        check("fill_dso_ignored_data", {24'b0, RES_DATA}, {24'b0, last_res});
        check("fill_ack_ignored", {29'b0, state_dbg}, {29'b0, S_FILL});
        @(posedge CLK); #1;

        // Gapped input, DSO only during SEND, then timeout
        for (int i = 0; i < 9; i++) w[i] = 8'(8'h10 + i);
        feed(w, 0, 9, 1'b1, rdy);
        wait_send(1'b1);
        n = 0;
        forever begin
            @(negedge CLK);
            if (TIMEOUT || n > 300) break;
            check("wait_res_valid_low", {31'b0, RES_VALID}, 32'd0);
            n++;
            @(posedge CLK); #1;
        end
        check("timeout_latency", n, TO_CYC);
        check("timeout_res_valid", {31'b0, RES_VALID}, 32'd0);
        check("timeout_res_data", {24'b0, RES_DATA}, {24'b0, last_res});
        check("timeout_to_fill", {31'b0, IN_READY}, 32'd1);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("timeout_one_cycle", {31'b0, TIMEOUT}, 32'd0);
        @(posedge CLK); #1;

        // DSO on the timeout cycle wins
        rand_win(w); feed(w, 0, 9, 1'b0, rdy);
        wait_send(1'b0);
        do_result(median9(w), TO_CYC - 1, 0);

`ifdef MEDIAN_FEEDER_STATS_EN
        check("win_cnt", {16'b0, WIN_CNT}, exp_win);
`endif
        check("exp_q_drained", exp_q.size(), 0);
        check("res_q_drained", res_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/median_feeder.md
MEDIAN_FEEDER -- requirements
Module: median_feeder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the number of cycles to wait for DSO before abandoning a window (range 2..255).
REQ-002 SHALL have port CLK, input, 1 bit: clock; all logic on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset, asynchronous, active-low; clock CLK.
REQ-004 SHALL have port IN_DATA, input, 8 bits: host pixel byte.
REQ-005 SHALL have port IN_VALID, input, 1 bit: host byte valid.
REQ-006 SHALL have port IN_READY, output, 1 bit: block accepts a host byte this cycle.
REQ-007 SHALL have port DI, output, 8 bits: pixel to the median filter.
REQ-008 SHALL have port DSI, output, 1 bit: pixel strobe to the median filter.
REQ-009 SHALL have port DO, input, 8 bits: median result from the filter.
REQ-010 SHALL have port DSO, input, 1 bit: result strobe from the filter.
REQ-011 SHALL have port RES_DATA, output, 8 bits: captured median.
REQ-012 SHALL have port RES_VALID, output, 1 bit: RES_DATA holds an unacknowledged result.
REQ-013 SHALL have port RES_ACK, input, 1 bit: host consumes the result.
REQ-014 SHALL have port TIMEOUT, output, 1 bit: one-cycle pulse when a window is abandoned.

Function
REQ-015 SHALL implement the states IDLE, FILL, SEND, WAIT and HOLD; IDLE moves to FILL unconditionally on the first clock after reset release.
REQ-016 In FILL, SHALL drive IN_READY=1 and store IN_DATA into buf[k] on each cycle with IN_VALID=1, k=0..8 in arrival order; IN_VALID=0 cycles insert gaps and store nothing.
REQ-017 On acceptance of buf[8], SHALL drive IN_READY=0 from the next cycle and enter SEND.
REQ-018 IN_READY SHALL be 0 in every state other than FILL.
REQ-019 In SEND, SHALL drive DSI=1 for exactly 9 consecutive registered cycles, with DI=buf[0]..buf[8] in order.
REQ-020 The first DSI=1 cycle SHALL be the cycle immediately after buf[8] is accepted.
REQ-021 Whenever DSI=0, DI SHALL be 0x00.
REQ-022 After the 9th SEND cycle, SHALL enter WAIT with an 8-bit wait counter cleared to 0; the counter increments once per WAIT cycle.
REQ-023 In WAIT, on DSO=1, SHALL register DO into RES_DATA and set RES_VALID=1 on the next cycle, then enter HOLD.
REQ-024 In WAIT, if the counter reaches TIMEOUT_CYCLES-1 with DSO=0, SHALL pulse TIMEOUT=1 for one cycle, leave RES_VALID=0 and RES_DATA unchanged, and enter FILL.
REQ-025 If DSO=1 arrives on the same cycle as the timeout condition, DSO SHALL win: capture the result and assert no TIMEOUT.
REQ-026 DSO=1 in any state other than WAIT SHALL be ignored.
REQ-027 In HOLD, RES_VALID and RES_DATA SHALL stay stable until RES_ACK=1 is sampled.
REQ-028 When RES_ACK=1 is sampled in HOLD, SHALL clear RES_VALID on the next cycle and enter FILL.
REQ-029 RES_ACK SHALL be ignored while RES_VALID=0.

Reset
REQ-030 reset=0 SHALL, regardless of the current state including mid-SEND or mid-WAIT, force: state IDLE, IN_READY=0, DSI=0, DI=0x00, RES_DATA=0x00, RES_VALID=0, TIMEOUT=0, wait counter=0, byte index=0.
REQ-031 buf contents SHALL not be reset; a partially filled window SHALL be discarded.

Configuration
REQ-032 When macro MEDIAN_FEEDER_STATS_EN is defined, SHALL add output WIN_CNT, 16 bits: count of results captured.
REQ-033 WIN_CNT SHALL increment on each REQ-023 capture and saturate at 0xFFFF.
REQ-034 WIN_CNT SHALL reset to 0x0000 and SHALL NOT count timeouts.
REQ-035 When MEDIAN_FEEDER_STATS_EN is not defined, WIN_CNT and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-036 Stream 0x09,0x08,...,0x01 with IN_VALID held high -> IN_READY high for exactly 9 cycles; on the next cycle DSI high for 9 cycles carrying DI=0x09..0x01.
REQ-037 Filter model asserts DSO with DO=0x05 three cycles after the last DSI -> RES_DATA=0x05 and RES_VALID=1 one cycle later; RES_ACK after 4 cycles -> RES_VALID=0 and IN_READY=1 on the next cycle.
REQ-038 No DSO with TIMEOUT_CYCLES=64 -> a single TIMEOUT pulse 64 cycles after WAIT entry, RES_VALID stays 0, block returns to FILL.
REQ-039 IN_VALID toggled 1,0,0,1,... across 9 bytes 0x10..0x18 -> DI order is 0x10..0x18 with no gaps in DSI.
REQ-040 reset asserted on the 5th SEND cycle -> DSI=0 and DI=0x00 immediately; after release, a fresh 9-byte fill is required before any DSI.
REQ-041 With MEDIAN_FEEDER_STATS_EN defined, 3 captured windows plus 1 timeout -> WIN_CNT=3.
